// File: rtl/mux16_rr_sel_ctrl.sv
// Round-robin select controller for the 16-to-1 mux: arbitrates 16 requesters,
// drives the mux select plus a one-hot grant, and forces rotation after MAX_HOLD cycles.
module mux16_rr_sel_ctrl #(
    parameter int N_REQ    = 16,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int                HOLD_W    = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]  search_start;
    logic [SEL_W:0]    search_res;
    logic              win_found;
    logic [SEL_W-1:0]  win_idx;
    logic              others_pending;
    logic              grant_new;

    // Cyclic first-set search; the descending loop lets the smallest offset win.
    function automatic logic [SEL_W:0] rr_search(input logic [N_REQ-1:0] r,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    // Release and preemption both restart the scan just past the current holder.
    assign search_start   = (state_q == IDLE) ? ptr_q : sel_q + SEL_W'(1);
    assign search_res     = rr_search(req, search_start);
    assign win_found      = search_res[SEL_W];
    assign win_idx        = search_res[SEL_W-1:0];
    assign others_pending = |(req & ~gnt_q);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_new  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && win_found) grant_new = 1'b1;
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (en && win_found) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                    end
                end else if (hold_cnt_q == HOLD_LAST && en && others_pending) begin
                    ptr_d     = sel_q + SEL_W'(1);
                    grant_new = 1'b1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_new) begin
            state_d    = GRANT;
            sel_d      = win_idx;
            gnt_d      = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule
